// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - LED mode encodings and channel-index width helper.
// Shared by led_array_ctrl and led_channel.
package led_pkg;

  typedef enum logic [1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_BLINK = 2'd2,
    LED_DIM   = 2'd3
  } led_mode_t;

  function automatic int cw_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_channel.sv
// rtl/led_channel.sv - one LED channel: mode/level registers and output decode.
// With LED_FADE_EN the level ramps toward the target one step per fade tick.
module led_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr,
  input  logic [1:0]          mode_in,
  input  logic [PWM_BITS-1:0] duty_in,
  input  logic                phase,
  input  logic [PWM_BITS-1:0] pwm_cnt,
`ifdef LED_FADE_EN
  input  logic                fade_tick,
`endif
  output logic                led
);

  localparam logic [PWM_BITS-1:0] MAX = '1;

  led_mode_t           mode;
  logic [PWM_BITS-1:0] level;

  function automatic logic [PWM_BITS-1:0] target_of(input led_mode_t m,
                                                    input logic [PWM_BITS-1:0] d);
    case (m)
      LED_ON:  return MAX;
      LED_DIM: return d;
      default: return '0;
    endcase
  endfunction

`ifdef LED_FADE_EN
  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS-1:0] target;
  assign target = target_of(mode, duty);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode  <= LED_OFF;
      level <= '0;
      led   <= 1'b0;
`ifdef LED_FADE_EN
      duty  <= '0;
`endif
    end else begin
      // OFF/ON/DIM all decode through level; level == MAX keeps ON steadily lit
      led <= (mode == LED_BLINK) ? phase : ((level == MAX) || (pwm_cnt < level));
`ifdef LED_FADE_EN
      if (wr) begin
        mode <= led_mode_t'(mode_in);
        duty <= duty_in;
      end
      if (mode == LED_BLINK)
        level <= '0;
      else if (fade_tick && level < target)
        level <= level + 1'b1;
      else if (fade_tick && level > target)
        level <= level - 1'b1;
`else
      if (wr) begin
        mode  <= led_mode_t'(mode_in);
        level <= target_of(led_mode_t'(mode_in), duty_in);
      end
`endif
    end
  end

endmodule

// File: rtl/led_array_ctrl.sv
// rtl/led_array_ctrl.sv - multi-channel LED controller: command port, blink/PWM timebases.
// Optional LED_FADE_EN adds a shared fade tick for per-channel level ramping.
module led_array_ctrl
  import led_pkg::*;
#(
  parameter int CLK_FREQ      = 50000000,
  parameter int N_LEDS        = 3,
  parameter int BLINK_HZ      = 1,
  parameter int PWM_BITS      = 8,
  parameter int FADE_STEP_CYC = 4096,
  localparam int CW           = cw_of(N_LEDS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [CW-1:0]       cmd_chan,
  input  logic [1:0]          cmd_mode,
  input  logic [PWM_BITS-1:0] cmd_duty,
  output logic                cmd_err,
  output logic [N_LEDS-1:0]   leds
);

  localparam int HALF_RAW = CLK_FREQ / (2 * BLINK_HZ);
  localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int HW       = (HALF > 1) ? $clog2(HALF) : 1;

  logic [HW-1:0]       blink_cnt;
  logic                blink_phase;
  logic                blink_wrap;
  logic                phase_next;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                accept;
  logic                chan_ok;

  assign accept     = cmd_valid && cmd_ready;
  assign chan_ok    = 32'(cmd_chan) < N_LEDS;
  assign blink_wrap = (blink_cnt == HW'(HALF - 1));
  // Channels register the post-edge phase so leds toggle on the same edge as the phase
  assign phase_next = blink_phase ^ blink_wrap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_ready   <= 1'b0;
      cmd_err     <= 1'b0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      pwm_cnt     <= '0;
    end else begin
      cmd_ready   <= !accept;
      cmd_err     <= accept && !chan_ok;
      blink_cnt   <= blink_wrap ? '0 : blink_cnt + 1'b1;
      blink_phase <= phase_next;
      pwm_cnt     <= pwm_cnt + 1'b1;
    end
  end

`ifdef LED_FADE_EN
  localparam int FW = (FADE_STEP_CYC > 1) ? $clog2(FADE_STEP_CYC) : 1;

  logic [FW-1:0] fade_cnt;
  logic          fade_tick;

  assign fade_tick = (fade_cnt == FW'(FADE_STEP_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fade_cnt <= '0;
    else        fade_cnt <= fade_tick ? '0 : fade_cnt + 1'b1;
  end
`endif

  for (genvar i = 0; i < N_LEDS; i++) begin : g_chan
    led_channel #(.PWM_BITS(PWM_BITS)) u_chan (
      .clk      (clk),
      .reset    (reset),
      .wr       (accept && (cmd_chan == CW'(i))),
      .mode_in  (cmd_mode),
      .duty_in  (cmd_duty),
      .phase    (phase_next),
      .pwm_cnt  (pwm_cnt),
`ifdef LED_FADE_EN
      .fade_tick(fade_tick),
`endif
      .led      (leds[i])
    );
  end

endmodule
